pc_seq_unit: RTL and testbench

//  Parametrised program-counter sequencer for the fetch stage. Holds the PC register and

---
 rtl/pc_seq_unit.sv | 155 +++++++++++++++
 tb/tb_pc_seq_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch-stage program-counter sequencer.
// Holds the PC, selects the next PC (increment, branch, jalr, trap) and offers
// it to fetch over a valid/ready handshake. A redirect that arrives while the
// current beat is stalled is parked in a pending register until the next
// accept. Misaligned branch/jalr targets halt the sequencer until a trap.
module pc_seq_unit #(
    parameter int unsigned XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned INST_BYTES   = 4,
    parameter bit          ALIGN_CHECK  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    output logic [XLEN-1:0] pc_plus_inc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_pc,
    input  logic [XLEN-1:0] br_imm,
    input  logic            jalr_en,
    input  logic [XLEN-1:0] jalr_base,
    input  logic [XLEN-1:0] jalr_imm,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vec,
    output logic            misalign_err
);

    // Number of PC offset bits that must be zero for an aligned target.
    localparam int unsigned OFF_W = $clog2(INST_BYTES);
    localparam logic [XLEN-1:0] INC      = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] OFF_MASK = XLEN'(INST_BYTES - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            misalign_err_q, misalign_err_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jalr_tgt;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] trap_tgt;
    logic            redir_req;
    logic            redir_bad;
    logic            accept;

    // Redirect targets, priority selection between jalr and branch, alignment check.
    always_comb begin
        br_tgt    = br_pc + br_imm;
        jalr_tgt  = (jalr_base + jalr_imm) & ~XLEN'(1);
        trap_tgt  = trap_vec & ~OFF_MASK;
        redir_req = jalr_en | br_taken;
        redir_tgt = jalr_en ? jalr_tgt : br_tgt;
        redir_bad = ALIGN_CHECK && redir_req && (|redir_tgt[OFF_W-1:0]);
        accept    = fetch_valid_q & fetch_ready;
    end

    // Next-state and next-PC selection for the sequencer FSM.
    always_comb begin
        // NOTE: every _d starts as a copy of its _q so no path leaves a
        // variable unassigned; an unassigned path would infer a latch.
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        fetch_valid_d  = fetch_valid_q;
        misalign_err_d = misalign_err_q;
        pend_valid_d   = pend_valid_q;
        pend_pc_d      = pend_pc_q;

        if (trap_en) begin
            // Trap wins in every state and restarts fetch without waiting for ready.
            state_d        = ST_RUN;
            fetch_valid_d  = 1'b1;
            fetch_pc_d     = trap_tgt;
            pend_valid_d   = 1'b0;
            misalign_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d       = ST_RUN;
                    fetch_valid_d = 1'b1;
                    if (redir_bad) begin
                        state_d        = ST_HALT;
                        fetch_valid_d  = 1'b0;
                        misalign_err_d = 1'b1;
                    end else if (redir_req) begin
                        fetch_pc_d = redir_tgt;
                    end
                end
                ST_RUN: begin
                    if (redir_bad) begin
                        // Bad target is neither loaded nor parked; PC stays put.
                        state_d        = ST_HALT;
                        fetch_valid_d  = 1'b0;
                        misalign_err_d = 1'b1;
                        pend_valid_d   = 1'b0;
                    end else if (accept) begin
                        pend_valid_d = 1'b0;
                        if (redir_req) begin
                            fetch_pc_d = redir_tgt;
                        end else if (pend_valid_q) begin
                            fetch_pc_d = pend_pc_q;
                        end else begin
                            fetch_pc_d = fetch_pc_q + INC;
                        end
                    end else if (redir_req) begin
                        // Stalled beat: park the newest redirect for the next accept.
                        pend_valid_d = 1'b1;
                        pend_pc_d    = redir_tgt;
                    end
                end
                ST_HALT: begin
                    fetch_valid_d = 1'b0;
                end
                default: begin
                    state_d       = ST_HALT;
                    fetch_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset back to the boot condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_BOOT;
            fetch_pc_q     <= RESET_VECTOR;
            fetch_valid_q  <= 1'b0;
            misalign_err_q <= 1'b0;
            pend_valid_q   <= 1'b0;
            pend_pc_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            fetch_valid_q  <= fetch_valid_d;
            misalign_err_q <= misalign_err_d;
            pend_valid_q   <= pend_valid_d;
            pend_pc_q      <= pend_pc_d;
        end
    end

    assign fetch_valid  = fetch_valid_q;
    assign fetch_pc     = fetch_pc_q;
    assign misalign_err = misalign_err_q;
    assign pc_plus_inc  = fetch_pc_q + INC;

endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed bench for pc_seq_unit with hand-computed expectations.
module tb_pc_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;
    logic [31:0] pc_plus_inc;
    logic        br_taken;
    logic [31:0] br_pc;
    logic [31:0] br_imm;
    logic        jalr_en;
    logic [31:0] jalr_base;
    logic [31:0] jalr_imm;
    logic        trap_en;
    logic [31:0] trap_vec;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;

    pc_seq_unit #(
        .XLEN(32),
        .RESET_VECTOR(32'h0),
        .INST_BYTES(4),
        .ALIGN_CHECK(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetch_valid(fetch_valid),
        .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc),
        .pc_plus_inc(pc_plus_inc),
        .br_taken(br_taken),
        .br_pc(br_pc),
        .br_imm(br_imm),
        .jalr_en(jalr_en),
        .jalr_base(jalr_base),
        .jalr_imm(jalr_imm),
        .trap_en(trap_en),
        .trap_vec(trap_vec),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        br_taken = 1'b0;
        jalr_en  = 1'b0;
        trap_en  = 1'b0;
    endtask

    task automatic do_br(input logic [31:0] pc, input logic [31:0] imm);
        br_taken = 1'b1;
        br_pc    = pc;
        br_imm   = imm;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] pc, input logic v);
        check({tag, "_pc"}, fetch_pc, pc);
        check({tag, "_valid"}, {31'd0, fetch_valid}, {31'd0, v});
    endtask

    initial begin
        rst = 1'b1;
        fetch_ready = 1'b1;
        br_pc = '0; br_imm = '0; jalr_base = '0; jalr_imm = '0; trap_vec = '0;
        idle();
        #12;
        check_pc("rst", 32'h0, 1'b0);
        check("rst_err", {31'd0, misalign_err}, 32'd0);

        // 1: boot cycle then sequential stream
        step();
        rst = 1'b0;
        check_pc("boot", 32'h0, 1'b0);
        step(); check_pc("seq0", 32'h0, 1'b1);
        check("seq0_inc", pc_plus_inc, 32'h4);
        step(); check_pc("seq1", 32'h4, 1'b1);
        step(); check_pc("seq2", 32'h8, 1'b1);
        step(); check_pc("seq3", 32'hC, 1'b1);

        // 2: redirect while stalled is parked and applied on accept
        do_br(32'h0, 32'h40);
        step(); check_pc("br40", 32'h40, 1'b1);
        idle(); fetch_ready = 1'b0;
        step(); check_pc("stall0", 32'h40, 1'b1);
        do_br(32'h3C, 32'h100);
        step(); check_pc("stall_br", 32'h40, 1'b1);
        idle();
        step(); check_pc("stall1", 32'h40, 1'b1);
        fetch_ready = 1'b1;
        step(); check_pc("pend_apply", 32'h13C, 1'b1);
        step(); check_pc("pend_next", 32'h140, 1'b1);

        // 3: jalr beats branch, bit0 cleared
        jalr_en = 1'b1; jalr_base = 32'h2001; jalr_imm = 32'h3;
        do_br(32'h0, 32'h500);
        step(); check_pc("jalr", 32'h2004, 1'b1);
        idle();
        step(); check_pc("jalr_next", 32'h2008, 1'b1);

        // trap beats jalr, ignores ready, low bits of vector forced to 0
        fetch_ready = 1'b0;
        trap_en = 1'b1; trap_vec = 32'h303; jalr_en = 1'b1;
        step(); check_pc("trap_prio", 32'h300, 1'b1);
        idle();

        // later stalled redirect overwrites the pending one
        do_br(32'h800, 32'h800);
        step(); check_pc("ovw0", 32'h300, 1'b1);
        do_br(32'h1000, 32'h1000);
        step(); check_pc("ovw1", 32'h300, 1'b1);
        idle(); fetch_ready = 1'b1;
        step(); check_pc("ovw_apply", 32'h2000, 1'b1);

        // 4: misaligned branch halts; only trap exits
        do_br(32'h100, 32'h2);
        step(); check_pc("mis", 32'h2000, 1'b0);
        check("mis_err", {31'd0, misalign_err}, 32'd1);
        do_br(32'h0, 32'h500);
        step(); check_pc("halt_hold", 32'h2000, 1'b0);
        idle(); trap_en = 1'b1; trap_vec = 32'h80;
        step(); check_pc("trap_exit", 32'h80, 1'b1);
        check("trap_err", {31'd0, misalign_err}, 32'd0);
        idle();
        step(); check_pc("trap_next", 32'h84, 1'b1);

        // 5: wrap at top of address space
        do_br(32'h0, 32'hFFFF_FFFC);
        step(); check_pc("top", 32'hFFFF_FFFC, 1'b1);
        check("top_inc", pc_plus_inc, 32'h0);
        idle();
        step(); check_pc("wrap", 32'h0, 1'b1);
        step(); check_pc("wrap_next", 32'h4, 1'b1);

        // asynchronous reset while stalled with a pending redirect
        fetch_ready = 1'b0;
        do_br(32'h700, 32'h0);
        step(); check_pc("pre_rst", 32'h4, 1'b1);
        idle();
        #2 rst = 1'b1;
        #1 check_pc("async_rst", 32'h0, 1'b0);
        step();
        rst = 1'b0; fetch_ready = 1'b1;
        step(); check_pc("rst_run", 32'h0, 1'b1);
        step(); check_pc("pend_lost", 32'h4, 1'b1);

        // redirect during the boot cycle lands directly
        rst = 1'b1;
        step();
        rst = 1'b0;
        do_br(32'h10, 32'h10);
        step(); check_pc("boot_br", 32'h20, 1'b1);
        idle();
        step(); check_pc("boot_br_next", 32'h24, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
